// File: rtl/rd_req_tagger_pkg.sv
// rd_req_tagger_pkg
//   Types and constants shared by the read-request tagger and the ROB.
//   tid_next() is the single definition of tID wrap, so the issuing end and the
//   retiring end always step through the same 0..TID_MAX-1 sequence.
package rd_req_tagger_pkg;

    localparam int ID_WIDTH   = 4;
    localparam int ADDR_WIDTH = 32;
    localparam int TID_MAX    = 8;   // power of 2 not required
    localparam int TID_WIDTH  = $clog2(TID_MAX);

    typedef logic [TID_WIDTH-1:0]  tid_t;
    typedef logic [TID_WIDTH:0]    cnt_t;    // 0..TID_MAX inclusive
    typedef logic [ID_WIDTH-1:0]   axi_id_t;
    typedef logic [ADDR_WIDTH-1:0] axi_addr_t;

    localparam cnt_t CNT_MAX = cnt_t'(TID_MAX);
    localparam cnt_t CNT_ONE = cnt_t'(1);

    // Tagged request held in the output stage
    typedef struct packed {
        tid_t      tid;
        axi_addr_t addr;
    } tag_req_t;

    function automatic tid_t tid_next(input tid_t t);
        return (t == tid_t'(TID_MAX - 1)) ? '0 : t + tid_t'(1);
    endfunction

endpackage

// File: rtl/rd_req_tagger_if.sv
// rd_req_tagger_if
//   Bundles the AR input, tagged-request output, retire, lookup and status
//   signals of rd_req_tagger.
//   slave  : the tagger side (drives arready_o, req_*_o, lookup_id_o, outstanding_o, err_o)
//   master : the surrounding logic / bench side
interface rd_req_tagger_if;
    import rd_req_tagger_pkg::*;

    logic      arvalid_i;
    logic      arready_o;
    axi_id_t   arid_i;
    axi_addr_t araddr_i;
    logic      req_valid_o;
    logic      req_ready_i;
    tid_t      req_tid_o;
    axi_addr_t req_addr_o;
    logic      retire_valid_i;
    tid_t      retire_tid_i;
    tid_t      lookup_tid_i;
    axi_id_t   lookup_id_o;
    cnt_t      outstanding_o;
    logic      err_o;

    modport slave (
        input  arvalid_i, arid_i, araddr_i, req_ready_i,
               retire_valid_i, retire_tid_i, lookup_tid_i,
        output arready_o, req_valid_o, req_tid_o, req_addr_o,
               lookup_id_o, outstanding_o, err_o
    );

    modport master (
        output arvalid_i, arid_i, araddr_i, req_ready_i,
               retire_valid_i, retire_tid_i, lookup_tid_i,
        input  arready_o, req_valid_o, req_tid_o, req_addr_o,
               lookup_id_o, outstanding_o, err_o
    );

endinterface

// File: rtl/rd_req_tagger_tid_id_table.sv
// tid_id_table
//   TID_MAX x ID_WIDTH register file holding the original ARID of each tID.
//   One synchronous write, one asynchronous read. A read of the entry being
//   written in the same cycle returns the old contents.
//   clk, rst_n : clock, synchronous active-low reset (clears all entries)
//   we, waddr, wdata : write port
//   raddr, rdata     : combinational read port
module tid_id_table
    import rd_req_tagger_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    we,
    input  tid_t    waddr,
    input  axi_id_t wdata,
    input  tid_t    raddr,
    output axi_id_t rdata
);

    axi_id_t mem [TID_MAX];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < TID_MAX; i++) mem[i] <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Codes past TID_MAX-1 exist when TID_MAX is not a power of 2; read them as 0
    assign rdata = (int'(raddr) < TID_MAX) ? mem[raddr] : '0;

endmodule

// File: rtl/rd_req_tagger.sv
// rd_req_tagger
//   Front end of the DRAM-cache read path. Stamps each accepted AR request
//   with the next sequential tID, forwards it to tag-compare through a single
//   output register, remembers its ARID for the ROB, and caps in-flight reads
//   at TID_MAX. In-order retires from the ROB return credits.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : rd_req_tagger_if.slave (AR in, tagged req out, retire, lookup, status)
module rd_req_tagger
    import rd_req_tagger_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    rd_req_tagger_if.slave     bus
);

    tid_t     issue_ptr, retire_ptr;
    cnt_t     outstanding;
    logic     out_vld;
    tag_req_t out_q;
    logic     err;

    logic     out_free;
    logic     accept;
    logic     retire_ok;
    logic     retire_bad;

    // Output stage can take a new entry when empty or draining this cycle
    assign out_free      = !out_vld || bus.req_ready_i;
    assign bus.arready_o = rst_n && (outstanding < CNT_MAX) && out_free;
    assign accept        = bus.arvalid_i && bus.arready_o;

    // Retires must come back in issue order and only for live tIDs
    assign retire_ok  = bus.retire_valid_i && (outstanding != '0)
                        && (bus.retire_tid_i == retire_ptr);
    assign retire_bad = bus.retire_valid_i && !retire_ok;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_vld <= 1'b0;
            out_q   <= '0;
        end else if (accept) begin
            out_vld    <= 1'b1;
            out_q.tid  <= issue_ptr;
            out_q.addr <= bus.araddr_i;
        end else if (bus.req_ready_i) begin
            out_vld <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            issue_ptr   <= '0;
            retire_ptr  <= '0;
            outstanding <= '0;
            err         <= 1'b0;
        end else begin
            if (accept)    issue_ptr  <= tid_next(issue_ptr);
            if (retire_ok) retire_ptr <= tid_next(retire_ptr);
            case ({accept, retire_ok})
                2'b10:   outstanding <= outstanding + CNT_ONE;
                2'b01:   outstanding <= outstanding - CNT_ONE;
                default: outstanding <= outstanding;
            endcase
            if (retire_bad) err <= 1'b1;
        end
    end

    tid_id_table u_tbl (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (accept),
        .waddr (issue_ptr),
        .wdata (bus.arid_i),
        .raddr (bus.lookup_tid_i),
        .rdata (bus.lookup_id_o)
    );

    assign bus.req_valid_o   = out_vld;
    assign bus.req_tid_o     = out_q.tid;
    assign bus.req_addr_o    = out_q.addr;
    assign bus.outstanding_o = outstanding;
    assign bus.err_o         = err;

endmodule

// File: tb/tb_rd_req_tagger.sv
// tb_rd_req_tagger
//   Directed scenarios plus a randomized phase, checked against a transaction
//   level model: tIDs are accept-count mod TID_MAX, credits are accepts minus
//   legal retires, the output stage is a queue of accepted-but-not-taken requests.
module tb_rd_req_tagger;
    import rd_req_tagger_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rd_req_tagger_if bus();

    rd_req_tagger u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    // reference model state
    typedef struct {
        int        tid;
        axi_addr_t addr;
    } pend_t;

    int      n_acc, n_ret;
    bit      m_err;
    axi_id_t tbl [TID_MAX];
    pend_t   pq [$];

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int m_outst();
        return n_acc - n_ret;
    endfunction

    task automatic model_clear();
        n_acc = 0;
        n_ret = 0;
        m_err = 1'b0;
        pq.delete();
        for (int i = 0; i < TID_MAX; i++) tbl[i] = '0;
    endtask

    task automatic idle_inputs();
        bus.arvalid_i      = 1'b0;
        bus.arid_i         = '0;
        bus.araddr_i       = '0;
        bus.req_ready_i    = 1'b0;
        bus.retire_valid_i = 1'b0;
        bus.retire_tid_i   = '0;
        bus.lookup_tid_i   = '0;
    endtask

    task automatic check_regs();
        chk("req_valid", bus.req_valid_o, pq.size() != 0);
        if (pq.size() != 0) begin
            chk("req_tid", bus.req_tid_o, pq[0].tid);
            chk("req_addr", bus.req_addr_o, pq[0].addr);
        end
        chk("outstanding", bus.outstanding_o, m_outst());
        chk("err", bus.err_o, m_err);
    endtask

    // One clock: check registered state, drive, check combinational outputs,
    // clock the DUT, advance the model.
    task automatic step(input bit av, input axi_id_t id, input axi_addr_t ad,
                        input bit rdy, input bit rv, input tid_t rt, input tid_t lt);
        bit exp_ar, acc, xfer, ret_ok;
        @(negedge clk);
        check_regs();
        bus.arvalid_i      = av;
        bus.arid_i         = id;
        bus.araddr_i       = ad;
        bus.req_ready_i    = rdy;
        bus.retire_valid_i = rv;
        bus.retire_tid_i   = rt;
        bus.lookup_tid_i   = lt;
        #1;
        exp_ar = (m_outst() < TID_MAX) && (pq.size() == 0 || rdy);
        chk("arready", bus.arready_o, exp_ar);
        chk("lookup", bus.lookup_id_o, tbl[lt]);
        acc    = av && exp_ar;
        xfer   = (pq.size() != 0) && rdy;
        ret_ok = rv && (m_outst() > 0) && (int'(rt) == n_ret % TID_MAX);
        @(posedge clk);
        if (xfer) void'(pq.pop_front());
        if (acc) begin
            pq.push_back('{n_acc % TID_MAX, ad});
            tbl[n_acc % TID_MAX] = id;
            n_acc++;
        end
        if (ret_ok) n_ret++;
        else if (rv) m_err = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n              = 1'b0;
        bus.arvalid_i      = 1'b1;
        bus.req_ready_i    = 1'b1;
        bus.retire_valid_i = 1'b1;
        #1;
        chk("rst_arready", bus.arready_o, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle_inputs();
        model_clear();
        #1;
        chk("rst_req_valid", bus.req_valid_o, 1'b0);
        chk("rst_req_tid", bus.req_tid_o, 0);
        chk("rst_req_addr", bus.req_addr_o, 0);
        chk("rst_outstanding", bus.outstanding_o, 0);
        chk("rst_err", bus.err_o, 1'b0);
        chk("rst_arready_rel", bus.arready_o, 1'b1);
        for (int i = 0; i < TID_MAX; i++) begin
            bus.lookup_tid_i = tid_t'(i);
            #1;
            chk("rst_table", bus.lookup_id_o, 0);
        end
    endtask

    function automatic axi_id_t rid();
        return axi_id_t'($urandom);
    endfunction

    function automatic axi_addr_t raddr();
        return axi_addr_t'($urandom);
    endfunction

    function automatic tid_t rtid();
        return tid_t'($urandom_range(TID_MAX - 1, 0));
    endfunction

    function automatic tid_t exp_ret_tid();
        return tid_t'(n_ret % TID_MAX);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        idle_inputs();
        model_clear();

        // single read
        do_reset();
        step(1'b1, 4'd5, 32'h1000, 1'b0, 1'b0, '0, '0);
        #1;
        chk("single_valid", bus.req_valid_o, 1'b1);
        chk("single_tid", bus.req_tid_o, 0);
        chk("single_addr", bus.req_addr_o, 32'h1000);
        chk("single_outst", bus.outstanding_o, 1);
        bus.lookup_tid_i = '0;
        #1;
        chk("single_lookup", bus.lookup_id_o, 5);

        // fill all credits, then free one
        do_reset();
        for (int i = 0; i < TID_MAX; i++) step(1'b1, rid(), raddr(), 1'b1, 1'b0, '0, rtid());
        step(1'b1, rid(), raddr(), 1'b1, 1'b0, '0, rtid());
        #1;
        chk("fill_outst", bus.outstanding_o, TID_MAX);
        chk("fill_arready", bus.arready_o, 1'b0);
        step(1'b1, rid(), raddr(), 1'b1, 1'b1, '0, rtid());
        step(1'b1, 4'd9, 32'h2000, 1'b1, 1'b0, '0, '0);
        #1;
        chk("fill_reuse_valid", bus.req_valid_o, 1'b1);
        chk("fill_reuse_tid", bus.req_tid_o, 0);

        // backpressure
        do_reset();
        step(1'b1, 4'd3, 32'hA0, 1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 3; i++) step(1'b1, rid(), raddr(), 1'b0, 1'b0, '0, '0);
        #1;
        chk("bp_hold_addr", bus.req_addr_o, 32'hA0);
        chk("bp_hold_tid", bus.req_tid_o, 0);
        step(1'b0, '0, '0, 1'b1, 1'b0, '0, '0);
        step(1'b1, 4'd4, 32'hB0, 1'b1, 1'b0, '0, '0);
        #1;
        chk("bp_next_tid", bus.req_tid_o, 1);
        chk("bp_next_addr", bus.req_addr_o, 32'hB0);

        // simultaneous accept + retire at 3 outstanding
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, rid(), raddr(), 1'b1, 1'b0, '0, rtid());
        step(1'b1, rid(), raddr(), 1'b1, 1'b1, '0, rtid());
        #1;
        chk("sim_outst", bus.outstanding_o, 3);
        chk("sim_tid", bus.req_tid_o, 3);
        step(1'b0, '0, '0, 1'b1, 1'b1, 3'd1, rtid());

        // wrap: 20 requests with streaming retire
        do_reset();
        for (int i = 0; i < 60 && !(n_acc == 20 && m_outst() == 0 && pq.size() == 0); i++)
            step(n_acc < 20, rid(), raddr(), 1'b1, m_outst() > 1 || n_acc == 20,
                 exp_ret_tid(), rtid());
        #1;
        chk("wrap_outst", bus.outstanding_o, 0);
        chk("wrap_err", bus.err_o, 1'b0);
        chk("wrap_valid", bus.req_valid_o, 1'b0);

        // randomized traffic, mostly-legal retires
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            bit   rv;
            tid_t rt;
            rv = ($urandom_range(99, 0) < 45);
            rt = ($urandom_range(99, 0) < 97) ? exp_ret_tid() : rtid();
            step($urandom_range(99, 0) < 70, rid(), raddr(), $urandom_range(99, 0) < 75,
                 rv, rt, rtid());
        end

        // illegal retire, then reset mid-operation
        do_reset();
        step(1'b1, rid(), raddr(), 1'b1, 1'b0, '0, rtid());
        step(1'b1, rid(), raddr(), 1'b1, 1'b0, '0, rtid());
        step(1'b0, '0, '0, 1'b1, 1'b1, 3'd2, rtid());
        #1;
        chk("illegal_err", bus.err_o, 1'b1);
        chk("illegal_outst", bus.outstanding_o, 2);
        step(1'b0, '0, '0, 1'b1, 1'b1, 3'd0, rtid());
        #1;
        chk("illegal_sticky", bus.err_o, 1'b1);
        do_reset();
        step(1'b0, '0, '0, 1'b1, 1'b0, '0, '0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
